// File: rtl/arm7tdmi_ifetch_bridge.sv
// arm7tdmi_ifetch_bridge: turns a held fetch request into one registered word read on the instruction bus.
// Optional one-word line buffer enabled by defining ARM7TDMI_IFETCH_LINEBUF_EN.
module arm7tdmi_ifetch_bridge #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] imem_vaddr,
    input  logic              imem_req,
    input  logic              imem_write,
    input  logic [1:0]        imem_size,
    output logic [31:0]       imem_rdata,
    output logic              imem_ready,
    output logic              imem_abort,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_req,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, ABORT_RESP, DISCARD} state_t;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              abort_q, abort_d;
    logic              legal;
    logic              timeout_hit;
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
    logic              lb_valid_q, lb_valid_d;
    logic [ADDR_W-3:0] lb_addr_q, lb_addr_d;
    logic [31:0]       lb_data_q, lb_data_d;
`endif

    assign legal       = imem_req && !imem_write && imem_size == 2'b10;
    assign timeout_hit = TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        abort_d    = 1'b0;
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
        lb_valid_d = lb_valid_q;
        lb_addr_d  = lb_addr_q;
        lb_data_d  = lb_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (imem_req && !legal) begin
                    state_d = ABORT_RESP;
                    abort_d = 1'b1;
                end else if (legal && !flush) begin
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
                    if (lb_valid_q && lb_addr_q == imem_vaddr[ADDR_W-1:2]) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        rdata_d = lb_data_q;
                    end else begin
                        state_d    = REQ;
                        bus_req_d  = 1'b1;
                        bus_addr_d = imem_vaddr & ~ADDR_W'(3);
                        cnt_d      = '0;
                    end
`else
                    state_d    = REQ;
                    bus_req_d  = 1'b1;
                    bus_addr_d = imem_vaddr & ~ADDR_W'(3);
                    cnt_d      = '0;
`endif
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                // A flush that coincides with the bus response consumes it here instead of waiting in DISCARD
                if (flush) begin
                    state_d   = (bus_ack || bus_err) ? IDLE : DISCARD;
                    bus_req_d = !(bus_ack || bus_err);
                end else if (bus_err) begin
                    state_d   = ABORT_RESP;
                    abort_d   = 1'b1;
                    bus_req_d = 1'b0;
                end else if (bus_ack) begin
                    state_d   = RESP;
                    ready_d   = 1'b1;
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
                    lb_valid_d = 1'b1;
                    lb_addr_d  = bus_addr_q[ADDR_W-1:2];
                    lb_data_d  = bus_rdata;
`endif
                end else if (timeout_hit) begin
                    state_d = DISCARD;
                    abort_d = 1'b1;
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
                    lb_valid_d = 1'b0;
`endif
                end
            end
            RESP, ABORT_RESP: state_d = IDLE;
            DISCARD: begin
                if (bus_ack || bus_err) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
        if (flush || (bus_req_q && bus_err)) lb_valid_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            abort_q    <= 1'b0;
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
            lb_valid_q <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            abort_q    <= abort_d;
`ifdef ARM7TDMI_IFETCH_LINEBUF_EN
            lb_valid_q <= lb_valid_d;
            lb_addr_q  <= lb_addr_d;
            lb_data_q  <= lb_data_d;
`endif
        end
    end

    // A flush arriving in the pulse cycle itself must still squash it, so it gates the registered pulse
    assign imem_ready = ready_q && !flush;
    assign imem_abort = abort_q && !flush;
    assign imem_rdata = rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_addr   = bus_addr_q;
    assign busy       = state_q != IDLE;
endmodule
